byte_deserializer: RTL
======================

BYTE_DESERIALIZER -- requirements
Module: byte_deserializer

Interface
REQ-001 Parameter MSB_FIRST, default 1: 1 means the first accepted bit lands in q[7]; 0 means it lands in q[0].
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 sin  input  1  serial data bit.
REQ-005 sin_valid  input  1  sin is accepted on a clk edge only when sin_valid=1; no backpressure on the serial side.
REQ-006 frame_start  input  1  qualified by sin_valid; marks the accepted bit as bit 0 of a new byte.
REQ-007 q  output  8  assembled byte, registered; feeds the downstream 8-bit register stage.
REQ-008 q_valid  output  1  q holds an unconsumed byte.
REQ-009 q_ready  input  1  downstream accepts q on an edge where q_valid=1 and q_ready=1.
REQ-010 overrun  output  1  sticky flag: a completed byte was dropped.
REQ-011 parity_err  output  1  parity mismatch flag for the byte currently in q.

Function
REQ-012 Internal state: 8-bit shift register, 4-bit bit counter cnt, FSM {SHIFT, PAR}; PAR exists only per REQ-027.
REQ-013 In SHIFT, each accepted bit is shifted in per MSB_FIRST, and cnt increments.
REQ-014 An accepted bit with frame_start=1 discards any partial byte and is stored as bit 0; cnt becomes 1.
REQ-015 frame_start=1 with sin_valid=0 has no effect.
REQ-016 Byte completion: on the edge accepting the 8th data bit (without parity), cnt wraps to 0 and the completed byte is offered to the output register on that same edge.
REQ-017 Latency: q and q_valid update on the same edge that accepts the final bit; q_valid is visible one cycle after the last sin_valid beat is presented.
REQ-018 Output load rule: a completed byte loads q and sets q_valid=1 if q_valid=0, or if q_valid=1 and q_ready=1 on that edge.
REQ-019 Simultaneous handoff and completion: the old byte transfers, the new byte loads, and q_valid stays 1 with no bubble.
REQ-020 Otherwise, when q_valid=1 and q_ready=0, the completed byte is dropped, q is unchanged, and overrun is set to 1.
REQ-021 overrun stays set until reset.
REQ-022 Transfer without a new byte: q_valid clears on the next edge, and q holds its last value.
REQ-023 q and parity_err remain stable while q_valid=1 and q_ready=0.
REQ-024 Back-to-back bytes: bits arriving on every cycle produce one byte per 8 cycles, with no gap cycles required.

Reset
REQ-025 While rst=1 on a clk edge: q=8'h00, q_valid=0, overrun=0, parity_err=0, cnt=0, FSM=SHIFT, shift register=0; rst has priority over every other input.
REQ-026 Reset mid-byte discards the partial byte; the first accepted bit after reset is bit 0, regardless of frame_start.

Configuration
REQ-027 With macro PARITY_CHECK_EN defined, the parity bit is handled as follows:
- After the 8th data bit, the FSM enters PAR.
- The next accepted bit is an even-parity bit.
- Completion, load and overrun (REQ-016..REQ-022) occur on the parity beat instead.
- parity_err is loaded with q and equals (XOR of 8 data bits) XOR parity bit.
- frame_start during PAR restarts a byte per REQ-014, and the pending byte is discarded.
REQ-028 Without PARITY_CHECK_EN:
- PAR is absent.
- Bytes are exactly 8 accepted bits.
- parity_err is driven constant 0.
- The port list is identical in both builds.

Verification
REQ-029 Reset, then bits 1,0,1,0,0,1,0,1 (MSB_FIRST=1) on consecutive cycles with q_ready=1 -> q=8'hA5, q_valid=1 for exactly one cycle, overrun=0.
REQ-030 MSB_FIRST=0, same bit stream -> q=8'hA5 bit-reversed = 8'hA5 (palindrome); repeat with stream 1,0,0,0,0,0,0,0 -> q=8'h01.
REQ-031 q_ready=0, send 8'h3C then 8'hC3 -> q holds 8'h3C, overrun=1 after the second byte completes; raise q_ready -> 8'h3C transfers, q_valid=0.
REQ-032 Continuous bits, q_ready=1, with the 8th bit of byte 2 on the same edge byte 1 is taken -> q_valid stays 1, q goes 8'h11 -> 8'h22.
REQ-033 Send 5 bits, then frame_start with the full byte 8'hF0 -> q=8'hF0; rst asserted after 3 bits, then 8'h0F -> q=8'h0F.
REQ-034 PARITY_CHECK_EN: 8'hA5 with parity 0 -> parity_err=0; with parity 1 -> parity_err=1; q=8'hA5 in both cases.

Source files
------------

// File: rtl/byte_deserializer.sv
// Serial-to-parallel byte assembler with a one-deep registered output and sticky overrun flag.
// Optional even-parity beat after each byte: define PARITY_CHECK_EN.
module byte_deserializer #(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sin,
    input  logic       sin_valid,
    input  logic       frame_start,
    output logic [7:0] q,
    output logic       q_valid,
    input  logic       q_ready,
    output logic       overrun,
    output logic       parity_err
);

`ifdef PARITY_CHECK_EN
    typedef enum logic [0:0] {
        ST_SHIFT = 1'b0,
        ST_PAR   = 1'b1
    } state_t;
`else
    typedef enum logic [0:0] {
        ST_SHIFT = 1'b0
    } state_t;
`endif

    function automatic logic [7:0] insert_bit(input logic [7:0] cur, input logic b);
        if (MSB_FIRST) begin
            return {cur[6:0], b};
        end else begin
            return {b, cur[7:1]};
        end
    endfunction

`ifdef PARITY_CHECK_EN
    function automatic logic even_parity8(input logic [7:0] d);
        return ^d;
    endfunction
`endif

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] q_q, q_d;
    logic       q_valid_q, q_valid_d;
    logic       overrun_q, overrun_d;
    logic       done_s;
    logic [7:0] byte_s;
`ifdef PARITY_CHECK_EN
    logic       perr_s;
    logic       perr_q, perr_d;
`endif

    // Bit assembly and framing: decides when a byte (and its parity) is complete.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        done_s  = 1'b0;
        byte_s  = shift_q;
`ifdef PARITY_CHECK_EN
        perr_s  = 1'b0;
`endif
        if (sin_valid) begin
            if (frame_start) begin
                shift_d = insert_bit(8'h00, sin);
                cnt_d   = 4'd1;
                state_d = ST_SHIFT;
            end else begin
                case (state_q)
                    ST_SHIFT: begin
                        shift_d = insert_bit(shift_q, sin);
                        if (cnt_q == 4'd7) begin
                            cnt_d = 4'd0;
`ifdef PARITY_CHECK_EN
                            state_d = ST_PAR;
`else
                            done_s  = 1'b1;
                            byte_s  = insert_bit(shift_q, sin);
`endif
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end
`ifdef PARITY_CHECK_EN
                    // Parity beat: data already sits in shift_q, sin is the parity bit.
                    ST_PAR: begin
                        done_s  = 1'b1;
                        byte_s  = shift_q;
                        perr_s  = even_parity8(shift_q) ^ sin;
                        state_d = ST_SHIFT;
                    end
`endif
                    default: begin
                        state_d = ST_SHIFT;
                        cnt_d   = 4'd0;
                    end
                endcase
            end
        end else begin
            state_d = state_q;
        end
    end

    // Output holding register: load when empty or draining, else flag the drop.
    always_comb begin
        q_d       = q_q;
        q_valid_d = q_valid_q;
        overrun_d = overrun_q;
`ifdef PARITY_CHECK_EN
        perr_d    = perr_q;
`endif
        if (done_s) begin
            if (!q_valid_q || q_ready) begin
                q_d       = byte_s;
                q_valid_d = 1'b1;
`ifdef PARITY_CHECK_EN
                perr_d    = perr_s;
`endif
            end else begin
                overrun_d = 1'b1;
            end
        end else if (q_valid_q && q_ready) begin
            q_valid_d = 1'b0;
        end else begin
            q_valid_d = q_valid_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_SHIFT;
            cnt_q     <= 4'd0;
            shift_q   <= 8'h00;
            q_q       <= 8'h00;
            q_valid_q <= 1'b0;
            overrun_q <= 1'b0;
`ifdef PARITY_CHECK_EN
            perr_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            q_q       <= q_d;
            q_valid_q <= q_valid_d;
            overrun_q <= overrun_d;
`ifdef PARITY_CHECK_EN
            perr_q    <= perr_d;
`endif
        end
    end

    assign q       = q_q;
    assign q_valid = q_valid_q;
    assign overrun = overrun_q;
`ifdef PARITY_CHECK_EN
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule
